reel_sprite_fetch: RTL and testbench
====================================

# reel_sprite_fetch

Pixel-pipeline stage directly upstream of the 256×16 sprite ROMs. It converts the VGA scan position into a ROM word address for one 64×64, 1-bit-per-pixel reel sprite, with vertical scroll wrap-around for the spinning reel. After the ROM read returns, it selects the addressed bit and emits a pixel-on flag aligned to a delayed display-enable. Sprite position and scroll are latched once per frame, so a reel never tears mid-frame.

## Interface
- ROM_LAT, 2, ROM read latency in clk cycles from `rom_addr` to `rom_dout`. Legal range 0..2; use 0 for the combinational ROM, 1 for a single-registered ROM, 2 for the double-registered ROM.
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- de  in  1  display enable for the current pixel
- sprite_x  in  10  left edge of the sprite, screen pixels
- sprite_y  in  10  top edge of the sprite, screen pixels
- scroll  in  6  vertical reel offset in sprite rows
- rom_addr  out  8  ROM word address, registered
- rom_dout  in  16  ROM data; bit 15 is the leftmost pixel of the word
- pixel_on  out  1  sprite pixel is set at the delayed position
- pixel_valid  out  1  `de` delayed to align with `pixel_on`

## Operation
- **Frame latch.** `sprite_x`, `sprite_y` and `scroll` are captured into internal registers on any cycle where `hcount==0 && vcount==0`. All other cycles use the latched copies.
- **Offsets.** dx = hcount − x_lat and dy = vcount − y_lat, both computed at 11 bits signed.
  - in_win when 0 ≤ dx < SIZE and 0 ≤ dy < SIZE.
  - SIZE is 64, or 128 with scaling (see Configuration).
  - Screen-edge overlap needs no special case; the signed compare handles it.
- **Column and row.** col = dx[5:0], or dx[6:1] when scaled. row = (dy[5:0] + scroll_lat) mod 64, or (dy[6:1] + scroll_lat) mod 64 when scaled. Row arithmetic is 6-bit wrap, so row 63 + 1 gives 0.
- **Address.** When in_win is high, `rom_addr` ← {row, col[5:4]} at the next edge. When in_win is low, `rom_addr` holds its previous value.
- **Sideband pipeline.** Each cycle pushes {in_win, col[3:0], de} into a delay line of depth 1 + ROM_LAT.
- **Output.** At the delay-line tail:
  - `pixel_valid` = de_d.
  - `pixel_on` = in_win_d & de_d & rom_dout[15 − col_d].
- The block has no back-pressure. It accepts one pixel per cycle, every cycle.

## Timing
- Pixel latency is 1 + ROM_LAT cycles: inputs sampled at edge N produce `pixel_on`/`pixel_valid` valid after edge N+1+ROM_LAT. With the default ROM_LAT=2 this is 3 cycles.
- `rom_addr` updates at edge N+1.
- Reset values: `rom_addr`=0, `pixel_on`=0, `pixel_valid`=0, latched x/y/scroll = 0, all delay-line stages = 0.
- Reset asserted mid-frame:
  - All outputs drop to 0 asynchronously and in-flight pixels are discarded.
  - After release, the first valid output appears 1 + ROM_LAT cycles after the first sampled input.
  - Latched x/y/scroll stay 0 until the next frame-origin cycle.
- If the frame-origin pixel is itself inside the window, it uses the newly latched values; the latch and the address compute happen in the same cycle.

## Configuration
- `REEL_SPRITE_SCALE2X_EN`
- Defined: the sprite is drawn 2× in both axes.
  - SIZE is 128.
  - col and row use dx/dy right-shifted by 1.
  - Each ROM bit covers a 2×2 screen-pixel block.
- Undefined: 1× drawing, SIZE is 64, no shift logic is present.
- Latency is identical in both builds.

## Test plan
- **Reset.** Assert reset with `de`=1 streaming → `rom_addr`, `pixel_on` and `pixel_valid` read 0 during reset and on the first cycle after release.
- **Basic hit.** Latch x=100, y=50, scroll=0; ROM word 0x00 = 0x8001; ROM_LAT=2; drive hcount=100..115 at vcount=50 → `rom_addr`=0x00. `pixel_on`=1 exactly 3 cycles after hcount=100 and after hcount=115; 0 for hcount 101..114.
- **Scroll wrap.** Latch scroll=63, y=50 → vcount=50 drives `rom_addr`=0xFC. vcount=51 at hcount=100 drives `rom_addr`=0x00 (row wraps to 0).
- **Outside window.** hcount=99 and hcount=164 with de=1 → `pixel_valid`=1, `pixel_on`=0, `rom_addr` unchanged. Sprite at x=600 near the right edge → columns 0..39 are drawn and no false hits occur at hcount 0..23.
- **Frame latch.** Change sprite_x from 100 to 200 at vcount=60 → remaining rows of that frame still hit at hcount=100. The next frame hits at hcount=200 only after hcount=0, vcount=0 has passed.
- **Scaled build** (`REEL_SPRITE_SCALE2X_EN` defined, x=100, y=50) → hcount 100 and 101 both give col 0. vcount 50 and 51 both give row 0. hcount=227 is inside the window; hcount=228 is outside it.

Source files
------------

// File: rtl/reel_sprite_fetch.sv
// ---------------------------------------------------------------------------
// reel_sprite_fetch
//
// Pixel-pipeline stage in front of a 256x16 sprite ROM. Converts the scan
// position into the ROM word address of one 64x64, 1-bpp reel sprite, with
// 6-bit vertical scroll wrap. A sideband delay line carries the in-window
// flag, the bit index inside the word and the display enable forward, so that
// the addressed ROM bit and the delayed enable line up at the output.
// Sprite position and scroll are latched at the frame-origin pixel
// (hcount==0 && vcount==0), so a reel never tears mid-frame.
//
// Build option: define REEL_SPRITE_SCALE2X_EN to draw the sprite 2x in both
// axes (128x128 window, each ROM bit covers a 2x2 pixel block). Latency is
// the same in both builds.
//
// Parameters
//   ROM_LAT      ROM read latency (rom_addr -> rom_dout) in clk cycles, 0..2
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   hcount       current pixel column
//   vcount       current pixel row
//   de           display enable for the current pixel
//   sprite_x     left edge of the sprite (screen pixels)
//   sprite_y     top edge of the sprite (screen pixels)
//   scroll       vertical reel offset in sprite rows
//   rom_addr     registered ROM word address {row, col[5:4]}
//   rom_dout     ROM data, bit 15 is the leftmost pixel of the word
//   pixel_on     sprite pixel is set at the delayed position
//   pixel_valid  de delayed to align with pixel_on
// ---------------------------------------------------------------------------
module reel_sprite_fetch #(
  parameter int ROM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        de,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [5:0]  scroll,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        pixel_on,
  output logic        pixel_valid
);

  // Sideband travelling alongside the ROM read.
  typedef struct packed {
    logic       in_win;
    logic [3:0] col;
    logic       de;
  } side_t;

  logic [9:0]  x_lat, y_lat;
  logic [5:0]  scroll_lat;

  logic        origin;
  logic [9:0]  x_eff, y_eff;
  logic [5:0]  scroll_eff;
  logic [10:0] dx, dy;
  logic        in_win;
  logic [5:0]  col, row;

  side_t       sb_q [ROM_LAT+1];
  side_t       sb_new;
  side_t       tail;

  // The origin pixel uses the values being latched on the same edge, so
  // bypass the latch registers on that one cycle.
  // NOTE: every always_comb output is assigned before any branch so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    origin     = (hcount == 10'd0) && (vcount == 10'd0);
    x_eff      = origin ? sprite_x : x_lat;
    y_eff      = origin ? sprite_y : y_lat;
    scroll_eff = origin ? scroll   : scroll_lat;

    // 11-bit difference of two zero-extended 10-bit values: bit 10 is the
    // sign, so left/top screen-edge overlap needs no special case.
    dx = {1'b0, hcount} - {1'b0, x_eff};
    dy = {1'b0, vcount} - {1'b0, y_eff};

`ifdef REEL_SPRITE_SCALE2X_EN
    in_win = !dx[10] && (dx[9:7] == 3'd0) && !dy[10] && (dy[9:7] == 3'd0);
    col    = dx[6:1];
    row    = dy[6:1] + scroll_eff;   // 6-bit wrap
`else
    in_win = !dx[10] && (dx[9:6] == 4'd0) && !dy[10] && (dy[9:6] == 4'd0);
    col    = dx[5:0];
    row    = dy[5:0] + scroll_eff;   // 6-bit wrap
`endif

    sb_new.in_win = in_win;
    sb_new.col    = col[3:0];
    sb_new.de     = de;
  end

`ifdef REEL_SPRITE_SCALE2X_EN
  // The half-pixel bit only selects within a 2x2 block; it is not needed.
  logic unused_lsb;
  assign unused_lsb = dx[0] ^ dy[0];
`endif

  // Frame latch.
  // NOTE: sequential state is written with non-blocking assignments so
  // every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lat      <= '0;
      y_lat      <= '0;
      scroll_lat <= '0;
    end else if (origin) begin
      x_lat      <= sprite_x;
      y_lat      <= sprite_y;
      scroll_lat <= scroll;
    end
  end

  // Address register: holds its value while the scan is outside the sprite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (in_win) begin
      rom_addr <= {row, col[5:4]};
    end
  end

  // Sideband delay line, depth 1 + ROM_LAT. Stage 0 is written on the same
  // edge as rom_addr; the tail lines up with rom_dout for that address.
  // NOTE: the delay line is reset (unlike a RAM) because a stale in_win/de
  // left in flight would produce a false pixel after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q[0] <= sb_new;
      for (int i = 1; i <= ROM_LAT; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Output: pick the addressed bit, leftmost pixel is bit 15.
  always_comb begin
    tail        = sb_q[ROM_LAT];
    pixel_valid = tail.de;
    pixel_on    = tail.in_win & tail.de & rom_dout[4'd15 - tail.col];
  end

endmodule

// File: tb/tb_reel_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tb_reel_sprite_fetch
//
// Bench for reel_sprite_fetch with a double-registered ROM (ROM_LAT = 2).
// A behavioural model derives the expected address and pixel from plain
// integer arithmetic on the scan position, the frame-latched sprite values
// and the ROM image; a compare process checks every cycle. Directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reel_sprite_fetch;

  localparam int LAT = 2;
`ifdef REEL_SPRITE_SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif
  localparam int SIZE = 64 * SCALE;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount, sprite_x, sprite_y;
  logic        de;
  logic [5:0]  scroll;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = '0;
  logic [15:0] rom_r1 = '0;
  logic        pixel_on, pixel_valid;

  logic [15:0] rom [256];

  int checks   = 0;
  int failures = 0;

  reel_sprite_fetch #(.ROM_LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .scroll      (scroll),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .pixel_on    (pixel_on),
    .pixel_valid (pixel_valid)
  );

  always #5 clk = ~clk;

  // Double-registered ROM.
  always @(posedge clk) begin
    rom_r1   <= rom[rom_addr];
    rom_dout <= rom_r1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit valid;
    bit on;
  } exp_t;

  exp_t       mq [LAT+1];
  logic [7:0] m_addr = '0;
  int         mx = 0, my = 0, ms = 0;

  always @(posedge clk or posedge reset) begin
    int   dxi, dyi, c, r, a;
    bit   win;
    exp_t e;
    if (reset) begin
      mx = 0; my = 0; ms = 0; m_addr = '0;
      for (int i = 0; i <= LAT; i++) mq[i] = '{0, 0};
    end else begin
      if (hcount == 0 && vcount == 0) begin
        mx = int'(sprite_x); my = int'(sprite_y); ms = int'(scroll);
      end
      dxi = int'(hcount) - mx;
      dyi = int'(vcount) - my;
      win = (dxi >= 0) && (dxi < SIZE) && (dyi >= 0) && (dyi < SIZE);
      e.valid = de;
      e.on    = 1'b0;
      if (win) begin
        c = dxi / SCALE;
        r = (dyi / SCALE + ms) % 64;
        a = r * 4 + c / 16;
        m_addr = 8'(a);
        e.on   = de && rom[a][15 - (c % 16)];
      end
      for (int i = LAT; i > 0; i--) mq[i] = mq[i-1];
      mq[0] = e;
    end
  end

  always @(negedge clk) begin
    check("pixel_valid", 16'(pixel_valid), 16'(mq[LAT].valid));
    check("pixel_on",    16'(pixel_on),    16'(mq[LAT].on));
    check("rom_addr",    16'(rom_addr),    16'(m_addr));
  end

  // ---------------- stimulus ----------------
  task automatic pix(input int h, input int v, input bit d);
    hcount = 10'(h);
    vcount = 10'(v);
    de     = d;
    @(negedge clk);
  endtask

  task automatic set_sprite(input int x, input int y, input int s);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    scroll   = 6'(s);
    pix(0, 0, 1);      // frame-origin cycle latches the new values
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 40503) ^ 16'h5A5A;
    rom[0] = 16'h8001;

    reset = 1'b1;
    sprite_x = '0; sprite_y = '0; scroll = '0;
    hcount = 10'd300; vcount = 10'd300; de = 1'b1;

    // Reset with de streaming, then the first cycle after release.
    repeat (3) begin
      @(negedge clk);
      check("reset_addr",  16'(rom_addr),    16'h0);
      check("reset_on",    16'(pixel_on),    16'h0);
      check("reset_valid", 16'(pixel_valid), 16'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_addr",  16'(rom_addr),    16'h0);
    check("post_reset_on",    16'(pixel_on),    16'h0);
    check("post_reset_valid", 16'(pixel_valid), 16'h0);
    pix(300, 300, 1);
    pix(300, 300, 1);

`ifndef REEL_SPRITE_SCALE2X_EN
    // Basic hit: word 0 = 0x8001, pixels at columns 0 and 15 only.
    set_sprite(100, 50, 0);
    for (int h = 100; h <= 117; h++) begin
      pix(h, 50, 1);
      if (h == 100) check("hit_addr", 16'(rom_addr), 16'h00);
      if (h >= 102) check("hit_on", 16'(pixel_on), 16'((h == 102) || (h == 117)));
    end

    // Scroll wrap.
    set_sprite(100, 50, 63);
    pix(100, 50, 1);
    check("wrap_row63", 16'(rom_addr), 16'h0FC);
    pix(100, 51, 1);
    check("wrap_row0", 16'(rom_addr), 16'h000);

    // Outside window: address holds, valid passes, no pixel.
    pix(99, 50, 1);
    check("left_hold", 16'(rom_addr), 16'h000);
    pix(164, 50, 1);
    check("right_hold", 16'(rom_addr), 16'h000);
    pix(164, 50, 1);
    check("outside_valid", 16'(pixel_valid), 16'h1);
    check("outside_on",    16'(pixel_on),    16'h0);

    // Frame latch: a mid-frame sprite_x change is ignored until origin.
    set_sprite(100, 50, 0);
    pix(100, 60, 1);
    check("latch_row10", 16'(rom_addr), 16'd40);
    sprite_x = 10'd200;
    pix(100, 61, 1);
    check("latch_old_x", 16'(rom_addr), 16'd44);
    pix(200, 61, 1);
    check("latch_new_x_ignored", 16'(rom_addr), 16'd44);
    pix(0, 0, 1);
    pix(200, 62, 1);
    check("next_frame_new_x", 16'(rom_addr), 16'd48);
    pix(100, 62, 1);
    check("next_frame_old_x_out", 16'(rom_addr), 16'd48);

    // Sprite near the right edge, then the line wraps to hcount 0..23.
    set_sprite(600, 50, 0);
    for (int h = 590; h <= 639; h++) begin
      pix(h, 50, 1);
      if (h == 602) check("edge_col0_on", 16'(pixel_on), 16'h1);
    end
    for (int h = 0; h <= 23; h++) pix(h, 51, 1);

    // Mid-frame reset: outputs drop asynchronously, latches return to 0.
    set_sprite(100, 50, 0);
    for (int h = 100; h <= 110; h++) pix(h, 55, 1);
    #2 reset = 1'b1;
    #1;
    check("async_addr",  16'(rom_addr),    16'h0);
    check("async_on",    16'(pixel_on),    16'h0);
    check("async_valid", 16'(pixel_valid), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    pix(20, 3, 1);
    check("latch_zero_after_reset", 16'(rom_addr), 16'd13);
    for (int h = 21; h <= 30; h++) pix(h, 3, 1);
`else
    // Scaled build: each ROM bit covers a 2x2 block, window is 128 wide.
    set_sprite(100, 50, 0);
    pix(140, 52, 1);
    check("s2_row1_col20", 16'(rom_addr), 16'd5);
    pix(100, 50, 1);
    check("s2_h100", 16'(rom_addr), 16'd0);
    pix(140, 52, 1);
    pix(101, 51, 1);
    check("s2_h101_v51", 16'(rom_addr), 16'd0);
    pix(100, 52, 1);
    check("s2_v52", 16'(rom_addr), 16'd4);
    pix(100, 53, 1);
    check("s2_v53", 16'(rom_addr), 16'd4);
    pix(227, 50, 1);
    check("s2_h227_in", 16'(rom_addr), 16'd3);
    pix(140, 52, 1);
    pix(228, 50, 1);
    check("s2_h228_out", 16'(rom_addr), 16'd5);
    for (int h = 90; h <= 240; h++) pix(h, 60, 1);
`endif

    // Drain with de low.
    for (int i = 0; i < 5; i++) pix(400, 400, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
